pipe_addsub: RTL
================

// Module: pipe_addsub
// PURPOSE
//  Parametrised, pipelined ripple adder/subtractor with valid/ready handshake.
//  WIDTH-bit operands are split into STAGES equal chunks. Each pipeline stage
//  ripples one chunk and registers the carry into the next stage.
//  Used wherever the datapath needs wide add/sub at full clock rate.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of chunks; 1..WIDTH; latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  in_valid   in   1      a, b, cin, sub valid this cycle
//  in_ready   out  1      block accepts the input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; acts as borrow-in when sub=1
//  sub        in   1      0: a+b+cin   1: a+~b+~cin (a-b-cin)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out of MSB; when sub=1, cout=0 means borrow
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits = 0, all data
//    regs = 0. Outputs: out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 after reset.
//  - Operand prep at input: b_eff = b ^ {WIDTH{sub}}; c_eff = cin ^ sub.
//  - Advance enable: adv = ~out_valid | out_ready. The whole pipe shifts on adv.
//    The pipe holds all state when adv=0. in_ready = adv (combinational).
//  - Transfer occurs when in_valid & in_ready. Bubbles (in_valid=0 while adv=1)
//    enter as valid=0.
//  - Stage k (0..STAGES-1) adds chunk k of a/b_eff plus the carry from stage
//    k-1 (c_eff for k=0). It registers sum chunk k and carry k. Not-yet-used
//    upper chunks are delayed (skewed). Already-computed lower sum chunks are
//    carried forward alongside.
//  - Latency: a transfer in cycle t gives out_valid=1 at t+STAGES, if the
//    pipe never stalls. Throughput: 1 result per cycle.
//  - sum/cout/ovf are registered and held stable while out_valid & ~out_ready.
//  - ovf = (a[MSB] ~^ b_eff[MSB]) & (sum[MSB] ^ a[MSB]). The sign bits of the
//    operand pair travel through the pipe with the data.
//  - Arithmetic is modulo 2^WIDTH. Wrap-around is reported only via cout/ovf.
//  - Simultaneous output pop and input push when full: both occur. No bubble
//    is inserted.
//  - Reset asserted mid-operation: in-flight results are discarded with no
//    partial output. out_valid drops in the same instant (async).
//  - STAGES=1: purely registered single-cycle adder with the same handshake.
// CONFIGURATION
//  ADDSUB_SATURATE_EN defined: when ovf=1, sum is clamped. A positive overflow
//   gives 0111..1; a negative overflow gives 1000..0. The clamp is applied in
//   the last stage with no added latency. ovf still reports the raw overflow.
//   cout is unaffected.
//  ADDSUB_SATURATE_EN undefined: sum is always the wrapped result.
// TESTING  (WIDTH=8, STAGES=2 unless noted)
//  1. Reset, then a=0x7F b=0x01 cin=0 sub=0, single push -> 2 cycles later
//     out_valid=1 sum=0x80 cout=0 ovf=1. With ADDSUB_SATURATE_EN: sum=0x7F.
//  2. a=0xFF b=0x01 cin=0 sub=0 -> sum=0x00 cout=1 ovf=0.
//     a=0x0F b=0xF0 cin=1 -> sum=0x00 cout=1 (carry crosses the chunk boundary).
//  3. sub=1 cin=0 a=0x05 b=0x07 -> sum=0xFE cout=0 ovf=0.
//     a=0x80 b=0x01 -> sum=0x7F ovf=1 (saturated: 0x80).
//  4. Push 8 back-to-back random ops. Hold out_ready=0 for 3 cycles mid-stream
//     -> in_ready=0 while full. Outputs stay stable. All 8 results arrive in
//     order and match the model, with none lost or duplicated.
//  5. Push 2 ops, assert reset 1 cycle later -> out_valid=0 immediately. No
//     result appears after release. in_ready=1.
//  6. Random regression, WIDTH=32 with STAGES in {1,4,32}, out_ready toggling
//     randomly -> every output matches a+b_eff+c_eff and the ovf/cout model.

Source files
------------

// File: rtl/pipe_addsub_if.sv
// Handshake bundle for pipe_addsub: input side (in_valid/in_ready, a, b,
// cin, sub) and output side (out_valid/out_ready, sum, cout, ovf).
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined ripple add/sub: WIDTH split in STAGES chunks, one chunk per stage.
// Ports: clk, reset (async high), bus (pipe_addsub_if.slave).
// Option: ADDSUB_SATURATE_EN clamps sum on signed overflow.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          reset,
  pipe_addsub_if.slave  bus
);
  localparam int CW = WIDTH / STAGES;

  logic adv;
  logic             ov_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign adv          = ~ov_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = ov_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;

  // Per-stage inputs. Operands are shifted right as chunks are consumed;
  // result chunks are shifted in from the top.
  logic [STAGES-1:0][WIDTH-1:0] a_i;
  logic [STAGES-1:0][WIDTH-1:0] b_i;
  logic [STAGES-1:0][WIDTH-1:0] s_i;
  logic [STAGES-1:0]            c_i;
  logic [STAGES-1:0]            v_i;
  logic [STAGES-1:0]            sa_i;
  logic [STAGES-1:0]            sb_i;

  assign a_i[0]  = bus.a;
  assign b_i[0]  = bus.b ^ {WIDTH{bus.sub}};
  assign s_i[0]  = '0;
  assign c_i[0]  = bus.cin ^ bus.sub;
  assign v_i[0]  = bus.in_valid;
  assign sa_i[0] = bus.a[WIDTH-1];
  assign sb_i[0] = bus.b[WIDTH-1] ^ bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CW:0]      add;
    logic [WIDTH-1:0] s_n;

    assign add = {1'b0, a_i[k][CW-1:0]}
               + {1'b0, b_i[k][CW-1:0]}
               + {{CW{1'b0}}, c_i[k]};
    assign s_n = (s_i[k] >> CW)
               | (WIDTH'(add[CW-1:0]) << (WIDTH - CW));

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             v_q;
      logic             sa_q;
      logic             sb_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q  <= '0;
          b_q  <= '0;
          s_q  <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
          sa_q <= 1'b0;
          sb_q <= 1'b0;
        end else if (adv) begin
          a_q  <= a_i[k] >> CW;
          b_q  <= b_i[k] >> CW;
          s_q  <= s_n;
          c_q  <= add[CW];
          v_q  <= v_i[k];
          sa_q <= sa_i[k];
          sb_q <= sb_i[k];
        end
      end

      assign a_i[k+1]  = a_q;
      assign b_i[k+1]  = b_q;
      assign s_i[k+1]  = s_q;
      assign c_i[k+1]  = c_q;
      assign v_i[k+1]  = v_q;
      assign sa_i[k+1] = sa_q;
      assign sb_i[k+1] = sb_q;
    end else begin : g_last
      logic             ovf_n;
      logic [WIDTH-1:0] r_n;

      // Same-sign operands giving a result of the other sign.
      assign ovf_n = (sa_i[k] ~^ sb_i[k])
                   & (s_n[WIDTH-1] ^ sa_i[k]);

`ifdef ADDSUB_SATURATE_EN
      // Operand sign picks the rail: + -> 0111..1, - -> 1000..0.
      assign r_n = ovf_n
                 ? {sa_i[k], {(WIDTH-1){~sa_i[k]}}}
                 : s_n;
`else
      assign r_n = s_n;
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ov_q   <= 1'b0;
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv) begin
          ov_q   <= v_i[k];
          sum_q  <= r_n;
          cout_q <= add[CW];
          ovf_q  <= ovf_n;
        end
      end
    end
  end
endmodule
